phold_engine: RTL and testbench
===============================

// Module: phold_engine
// PURPOSE
//  Hardware PHOLD discrete-event simulation kernel, instantiated once per AE personality.
//  Keeps a small timestamp-ordered pool of pending events and repeatedly processes the
//  earliest one. Each processed event writes one log record to host memory over MC
//  port 0 and schedules one pseudo-random successor event.
//  Stops when GVT (the minimum pending timestamp) reaches the configured end time.
//  Then reports GVT, the total cycle count and the total event count to the dispatch/AEG logic.
// PARAMETERS
//  NUM_MC_PORTS     16  number of MC ports; only port 0 is driven
//  MC_RTNCTL_WIDTH  32  width of each port's rtnctl field
//  QDEPTH           16  event pool entries; must be a power of 2, from 2 to 32
// PORTS
//  clk              in   1        core clock; the only clock
//  i_reset          in   1        asynchronous, active-high reset; deassertion starts a run
//  sim_end          in   16       simulation end time
//  addr             in   48       byte base address of the event log
//  num_init_events  in   8        number of initial events
//  lp_mask          in   8        AND-mask applied to the LP id
//  gvt              out  16       final GVT; valid when rtn_vld is 1
//  rtn_vld          out  1        one-cycle pulse at the end of the run
//  total_cycles     out  64       cycles spent in INIT and RUN
//  total_events     out  64       number of events processed
//  mc_rq_vld/cmd/scmd/vadr/size/rtnctl/data/flush  out  NUM_MC_PORTS x {1,3,4,48,2,RTNCTL,64,1}
//  mc_rq_stall      in   NUM_MC_PORTS
//  mc_rs_vld/cmd/scmd/rtnctl/data  in   response bundle; ignored
//  mc_rs_stall      out  NUM_MC_PORTS  tied to 0
// BEHAVIOUR
//  - Reset: every register is cleared and the engine enters INIT.
//    All outputs read 0, every mc_* output reads 0, LFSR is loaded with seed 16'hACE1.
//  - Event entry format: {valid, time[15:0], lp[7:0]}.
//  - INIT, one cycle per initial event: entry i <= {1, 16'd0, i[7:0] & lp_mask}.
//    Count n = min(num_init_events, QDEPTH). INIT lasts max(n,1) cycles, then the engine enters RUN.
//  - Minimum selection is combinational over the valid entries. The lowest index wins ties.
//    GVT = min time among valid entries. With no valid entries, GVT = sim_end.
//  - RUN, each cycle:
//    - If GVT >= sim_end, go to DONE and issue no request.
//    - Else if mc_rq_stall[0]=1, hold every register except total_cycles.
//    - Else process the min entry (t, lp) and do all of the following in that cycle:
//      - Issue a write on port 0: vld=1, cmd=3'd2 (WR), scmd=0, size=2'd3 (8 bytes).
//      - vadr = addr + {total_events[44:0], 3'b000}; rtnctl = 0.
//      - data = {24'd0, lp, 16'd0, t}.
//      - total_events increments.
//      - The same slot is overwritten with the successor event:
//        time = t + 1 + lfsr[3:0], saturating at 16'hFFFF; lp = lfsr[15:8] & lp_mask.
//      - The LFSR advances one step: Fibonacci, taps 16,14,13,11, shifted left, new bit into bit 0.
//  - mc_rq_vld is 1 only in processing cycles. Other ports and mc_rq_flush are always 0.
//    Writes are posted; write responses are not tracked.
//  - total_cycles increments every cycle in INIT and RUN, including stalled cycles. It freezes in DONE.
//  - DONE, entry cycle: rtn_vld=1 for exactly one cycle. gvt = GVT, clamped to sim_end when GVT > sim_end.
//    total_cycles and total_events are frozen. The engine then stays in DONE with rtn_vld=0 until reset.
//  - sim_end=0: INIT runs, then RUN detects GVT >= 0 on its first cycle. No writes; rtn_vld pulses; gvt=0.
//  - num_init_events=0: pool empty, GVT = sim_end, immediate DONE with total_events=0.
//  - Reset asserted mid-run aborts the run. Outstanding MC writes are abandoned.
//  - Inputs are sampled continuously. They must be held stable from reset release until rtn_vld.
// TESTING
//  - num_init_events=4, sim_end=0, lp_mask=8'hFF -> no mc_rq_vld; rtn_vld after 5 cycles; gvt=0, total_events=0.
//  - num_init_events=0, sim_end=100 -> rtn_vld; total_events=0; gvt=100.
//  - num_init_events=1, sim_end=2, addr=48'h1000 -> first write: vadr=48'h1000, data=0.
//    Successor time = 1 + (16'hACE1 & 4'hF) = 2, so GVT=2, rtn_vld fires, total_events=1.
//  - num_init_events=8, sim_end=1000, mc_rq_stall toggling randomly:
//    - write count equals total_events;
//    - vadr values are consecutive 8-byte addresses starting at addr;
//    - the t field in the write data is non-decreasing;
//    - total_cycles equals INIT+RUN cycles counted by the bench.
//  - lp_mask=8'h03 -> the lp field of every write is at most 3.
//  - Assert i_reset mid-RUN, then release -> all outputs return to 0 and a fresh run reproduces the same write sequence.

Source files
------------

// File: rtl/phold_engine.sv
// phold_engine: hardware PHOLD discrete-event simulation kernel.
//
// Holds a small pool of pending events {valid, time, lp}. After reset the
// pool is seeded with the initial events (INIT). In RUN the engine processes
// the earliest event once per cycle: it writes a log record on MC port 0
// and replaces that event with a pseudo-random successor. The run ends when
// GVT (the minimum pending timestamp) reaches sim_end. The engine then pulses
// rtn_vld with the final GVT and the cycle and event totals.
//
// Ports
//   clk, i_reset          core clock; asynchronous active-high reset (release starts a run)
//   sim_end, addr         simulation end time; byte base address of the event log
//   num_init_events       number of initial events (clipped to QDEPTH)
//   lp_mask               AND-mask applied to every LP id
//   gvt, rtn_vld          final GVT, qualified by the one-cycle rtn_vld pulse
//   total_cycles/events   INIT+RUN cycle count; processed event count
//   mc_rq_*               request bundle, flattened per port; only port 0 is used
//   mc_rq_stall           request back-pressure; only bit 0 matters
//   mc_rs_*               response bundle; ignored, mc_rs_stall tied low
module phold_engine #(
  parameter int NUM_MC_PORTS    = 16,
  parameter int MC_RTNCTL_WIDTH = 32,
  parameter int QDEPTH          = 16
) (
  input  logic                                    clk,
  input  logic                                    i_reset,
  input  logic [15:0]                             sim_end,
  input  logic [47:0]                             addr,
  input  logic [7:0]                              num_init_events,
  input  logic [7:0]                              lp_mask,
  output logic [15:0]                             gvt,
  output logic                                    rtn_vld,
  output logic [63:0]                             total_cycles,
  output logic [63:0]                             total_events,
  output logic [NUM_MC_PORTS-1:0]                 mc_rq_vld,
  output logic [NUM_MC_PORTS*3-1:0]               mc_rq_cmd,
  output logic [NUM_MC_PORTS*4-1:0]               mc_rq_scmd,
  output logic [NUM_MC_PORTS*48-1:0]              mc_rq_vadr,
  output logic [NUM_MC_PORTS*2-1:0]               mc_rq_size,
  output logic [NUM_MC_PORTS*MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
  output logic [NUM_MC_PORTS*64-1:0]              mc_rq_data,
  output logic [NUM_MC_PORTS-1:0]                 mc_rq_flush,
  input  logic [NUM_MC_PORTS-1:0]                 mc_rq_stall,
  input  logic [NUM_MC_PORTS-1:0]                 mc_rs_vld,
  input  logic [NUM_MC_PORTS*3-1:0]               mc_rs_cmd,
  input  logic [NUM_MC_PORTS*4-1:0]               mc_rs_scmd,
  input  logic [NUM_MC_PORTS*MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
  input  logic [NUM_MC_PORTS*64-1:0]              mc_rs_data,
  output logic [NUM_MC_PORTS-1:0]                 mc_rs_stall
);

  localparam int          IW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int          W_VLD  = NUM_MC_PORTS;
  localparam int          W_CMD  = NUM_MC_PORTS * 3;
  localparam int          W_SIZE = NUM_MC_PORTS * 2;
  localparam int          W_VADR = NUM_MC_PORTS * 48;
  localparam int          W_DATA = NUM_MC_PORTS * 64;
  localparam logic [8:0]  QD9    = 9'(QDEPTH);
  localparam logic [15:0] SEED   = 16'hACE1;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One step of the 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_t      r_state, w_next;
  logic        r_vld  [QDEPTH];
  logic [15:0] r_time [QDEPTH];
  logic [7:0]  r_lp   [QDEPTH];
  logic [8:0]  r_init_idx;
  logic [15:0] r_lfsr;
  logic [15:0] r_gvt;
  logic        r_rtn_vld;
  logic [63:0] r_cycles;
  logic [63:0] r_events;

  logic          w_found;
  logic          w_take;
  logic [15:0]   w_min_t;
  logic [IW-1:0] w_min_idx;
  logic [7:0]    w_min_lp;
  logic [15:0]   w_gvt;
  logic          w_done_cond;
  logic          w_proc;
  logic [8:0]    w_init_n;
  logic          w_init_last;
  logic [16:0]   w_succ_sum;
  logic [15:0]   w_succ_t;
  logic [47:0]   w_vadr;
  logic          w_unused;

  // Earliest valid entry; a later entry must be strictly earlier to win, so ties go to the lowest index.
  always_comb begin
    w_found   = 1'b0;
    w_min_t   = 16'hFFFF;
    w_min_idx = '0;
    w_take    = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      w_take    = r_vld[i] && (!w_found || (r_time[i] < w_min_t));
      w_found   = w_found | w_take;
      w_min_t   = w_take ? r_time[i] : w_min_t;
      w_min_idx = w_take ? IW'(i) : w_min_idx;
    end
  end

  assign w_min_lp    = r_lp[w_min_idx];
  assign w_gvt       = w_found ? w_min_t : sim_end;
  assign w_done_cond = (w_gvt >= sim_end);
  assign w_init_n    = ({1'b0, num_init_events} > QD9) ? QD9 : {1'b0, num_init_events};
  // With zero initial events INIT still takes one cycle, so the comparison is ">=".
  assign w_init_last = ((r_init_idx + 9'd1) >= w_init_n);
  assign w_succ_sum  = {1'b0, w_min_t} + 17'd1 + {13'd0, r_lfsr[3:0]};
  assign w_succ_t    = w_succ_sum[16] ? 16'hFFFF : w_succ_sum[15:0];
  assign w_vadr      = addr + {r_events[44:0], 3'b000};

  // State register.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and the per-cycle "process an event" decision.
  always_comb begin
    w_next = r_state;
    w_proc = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (w_init_last) begin
          w_next = ST_RUN;
        end else begin
          w_next = ST_INIT;
        end
      end
      ST_RUN: begin
        if (w_done_cond) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_RUN;
          w_proc = !mc_rq_stall[0];
        end
      end
      ST_DONE: w_next = ST_DONE;
      default: w_next = ST_INIT;
    endcase
  end

  // Event pool, LFSR, counters and the end-of-run report.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        r_vld[i]  <= 1'b0;
        r_time[i] <= 16'd0;
        r_lp[i]   <= 8'd0;
      end
      r_init_idx <= 9'd0;
      r_lfsr     <= SEED;
      r_gvt      <= 16'd0;
      r_rtn_vld  <= 1'b0;
      r_cycles   <= 64'd0;
      r_events   <= 64'd0;
    end else begin
      r_rtn_vld <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_cycles   <= r_cycles + 64'd1;
          r_init_idx <= r_init_idx + 9'd1;
          if (r_init_idx < w_init_n) begin
            r_vld[r_init_idx[IW-1:0]]  <= 1'b1;
            r_time[r_init_idx[IW-1:0]] <= 16'd0;
            r_lp[r_init_idx[IW-1:0]]   <= r_init_idx[7:0] & lp_mask;
          end
        end
        ST_RUN: begin
          r_cycles <= r_cycles + 64'd1;
          if (w_done_cond) begin
            r_rtn_vld <= 1'b1;
            r_gvt     <= (w_gvt > sim_end) ? sim_end : w_gvt;
          end else if (w_proc) begin
            r_events          <= r_events + 64'd1;
            r_time[w_min_idx] <= w_succ_t;
            r_lp[w_min_idx]   <= r_lfsr[15:8] & lp_mask;
            r_lfsr            <= lfsr_step(r_lfsr);
          end
        end
        default: begin
          r_cycles <= r_cycles;
        end
      endcase
    end
  end

  assign gvt          = r_gvt;
  assign rtn_vld      = r_rtn_vld;
  assign total_cycles = r_cycles;
  assign total_events = r_events;

  // Port 0 carries the posted log write during processing cycles only; every field reads 0 otherwise.
  assign mc_rq_vld    = W_VLD'(w_proc);
  assign mc_rq_cmd    = W_CMD'(w_proc ? 3'd2 : 3'd0);
  assign mc_rq_scmd   = '0;
  assign mc_rq_size   = W_SIZE'(w_proc ? 2'd3 : 2'd0);
  assign mc_rq_vadr   = W_VADR'(w_proc ? w_vadr : 48'd0);
  assign mc_rq_rtnctl = '0;
  assign mc_rq_data   = W_DATA'(w_proc ? {24'd0, w_min_lp, 16'd0, w_min_t} : 64'd0);
  assign mc_rq_flush  = '0;
  assign mc_rs_stall  = '0;

  // Responses are never tracked and only port 0 can stall us.
  assign w_unused = ^{mc_rq_stall[NUM_MC_PORTS-1:1], mc_rs_vld, mc_rs_cmd, mc_rs_scmd,
                      mc_rs_rtnctl, mc_rs_data};

endmodule

// File: tb/tb_phold_engine.sv
module tb_phold_engine;

  localparam int NP     = 16;
  localparam int RW     = 32;
  localparam int QD     = 16;
  localparam int BUDGET = 20000;

  logic               clk = 1'b0;
  logic               i_reset;
  logic [15:0]        sim_end;
  logic [47:0]        addr;
  logic [7:0]         num_init_events;
  logic [7:0]         lp_mask;
  logic [15:0]        gvt;
  logic               rtn_vld;
  logic [63:0]        total_cycles;
  logic [63:0]        total_events;
  logic [NP-1:0]      mc_rq_vld;
  logic [NP*3-1:0]    mc_rq_cmd;
  logic [NP*4-1:0]    mc_rq_scmd;
  logic [NP*48-1:0]   mc_rq_vadr;
  logic [NP*2-1:0]    mc_rq_size;
  logic [NP*RW-1:0]   mc_rq_rtnctl;
  logic [NP*64-1:0]   mc_rq_data;
  logic [NP-1:0]      mc_rq_flush;
  logic [NP-1:0]      mc_rq_stall;
  logic [NP-1:0]      mc_rs_vld;
  logic [NP*3-1:0]    mc_rs_cmd;
  logic [NP*4-1:0]    mc_rs_scmd;
  logic [NP*RW-1:0]   mc_rs_rtnctl;
  logic [NP*64-1:0]   mc_rs_data;
  logic [NP-1:0]      mc_rs_stall;

  int errors = 0;
  int checks = 0;

  // Observations of one run.
  logic [47:0] obs_vadr[$];
  logic [63:0] obs_data[$];
  logic [15:0] obs_gvt;
  logic [63:0] obs_tc, obs_te;
  int          obs_k, obs_bad, obs_extra, obs_unfrozen;
  bit          obs_done, obs_timeout;

  // Reference model results.
  int exp_t[$];
  int exp_lp[$];
  int exp_gvt;

  always #5 clk = ~clk;

  phold_engine #(.NUM_MC_PORTS(NP), .MC_RTNCTL_WIDTH(RW), .QDEPTH(QD)) dut (
    .clk(clk), .i_reset(i_reset), .sim_end(sim_end), .addr(addr),
    .num_init_events(num_init_events), .lp_mask(lp_mask), .gvt(gvt), .rtn_vld(rtn_vld),
    .total_cycles(total_cycles), .total_events(total_events),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
    .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
    .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
    .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data), .mc_rs_stall(mc_rs_stall)
  );

  // PHOLD reference: repeatedly take the earliest event (lowest slot on ties), log it,
  // replace it by its successor, until the earliest pending time reaches the end time.
  task automatic model_run(input int num, input int send, input int mask);
    bit v[QD];
    int tm[QD];
    int lpv[QD];
    int n, l, bi, gv, guard, fb;
    bit fin;
    exp_t.delete();
    exp_lp.delete();
    n = (num > QD) ? QD : num;
    for (int i = 0; i < QD; i++) begin
      v[i]   = (i < n);
      tm[i]  = 0;
      lpv[i] = i & mask;
    end
    l = 'hACE1;
    fin = 0;
    guard = 0;
    while (!fin && guard < 200000) begin
      guard++;
      bi = -1;
      for (int i = 0; i < QD; i++)
        if (v[i] && (bi < 0 || tm[i] < tm[bi])) bi = i;
      gv = (bi < 0) ? send : tm[bi];
      if (gv >= send) begin
        exp_gvt = (gv > send) ? send : gv;
        fin = 1;
      end else begin
        exp_t.push_back(tm[bi]);
        exp_lp.push_back(lpv[bi]);
        tm[bi]  = tm[bi] + 1 + (l % 16);
        if (tm[bi] > 65535) tm[bi] = 65535;
        lpv[bi] = (l / 256) & mask;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        l  = ((l * 2) + fb) % 65536;
      end
    end
  endtask

  // Number of observed writes that disagree with the model (including a length difference).
  function automatic int seq_mismatches(input logic [47:0] base);
    int m, n;
    logic [63:0] ed;
    n = (obs_data.size() < exp_t.size()) ? obs_data.size() : exp_t.size();
    m = (obs_data.size() > exp_t.size()) ? obs_data.size() - n : exp_t.size() - n;
    for (int i = 0; i < n; i++) begin
      ed = {24'd0, 8'(exp_lp[i]), 16'd0, 16'(exp_t[i])};
      if (obs_data[i] !== ed || obs_vadr[i] !== base + 48'(i) * 48'd8) m++;
    end
    return m;
  endfunction

  // Reset, release, and record everything the DUT does until rtn_vld (or abort_after cycles).
  task automatic do_run(input int num, input int send, input logic [47:0] base,
                        input logic [7:0] mask, input int stall_pct, input int abort_after);
    bit stop;
    obs_vadr.delete();
    obs_data.delete();
    obs_done = 0; obs_timeout = 0; obs_bad = 0; obs_extra = 0; obs_unfrozen = 0;
    obs_k = 0; obs_gvt = 16'd0; obs_tc = 64'd0; obs_te = 64'd0;
    @(negedge clk);
    i_reset         = 1'b1;
    num_init_events = 8'(num);
    sim_end         = 16'(send);
    addr            = base;
    lp_mask         = mask;
    mc_rq_stall     = '0;
    mc_rs_vld       = NP'($urandom);
    @(negedge clk);
    @(negedge clk);
    i_reset     = 1'b0;
    mc_rq_stall = {15'd0, ($urandom_range(0, 99) < stall_pct)};
    stop = 0;
    while (!stop) begin
      @(posedge clk);
      obs_k++;
      @(negedge clk);
      mc_rq_stall = {15'd0, ($urandom_range(0, 99) < stall_pct)};
      #1;
      if (mc_rq_vld[0]) begin
        obs_vadr.push_back(mc_rq_vadr[47:0]);
        obs_data.push_back(mc_rq_data[63:0]);
        if (mc_rq_cmd[2:0] !== 3'd2 || mc_rq_size[1:0] !== 2'd3 || mc_rq_stall[0] !== 1'b0)
          obs_bad++;
      end
      if (mc_rq_vld[NP-1:1] !== '0 || mc_rq_flush !== '0 || mc_rq_scmd !== '0 ||
          mc_rq_rtnctl !== '0 || (mc_rq_cmd >> 3) !== '0 || mc_rs_stall !== '0)
        obs_bad++;
      if (rtn_vld) begin
        obs_done = 1; obs_gvt = gvt; obs_tc = total_cycles; obs_te = total_events;
        stop = 1;
      end else if (abort_after > 0 && obs_k >= abort_after) begin
        stop = 1;
      end else if (obs_k >= BUDGET) begin
        obs_timeout = 1;
        stop = 1;
      end
    end
    if (obs_done) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk);
        @(negedge clk);
        #1;
        if (rtn_vld) obs_extra++;
        if (total_cycles !== obs_tc || total_events !== obs_te) obs_unfrozen++;
        if (mc_rq_vld !== '0) obs_bad++;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    i_reset = 1'b1; num_init_events = 8'd5; sim_end = 16'd50;
    addr = 48'h1234_5678_9ABC; lp_mask = 8'hFF; mc_rq_stall = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (gvt !== 16'd0 || rtn_vld !== 1'b0) begin
      errors++; $display("FAIL reset_report: gvt=%h rtn_vld=%b, required 0", gvt, rtn_vld); end
    checks++; if (total_cycles !== 64'd0 || total_events !== 64'd0) begin
      errors++; $display("FAIL reset_totals: cycles=%0d events=%0d, required 0", total_cycles, total_events); end
    checks++; if (mc_rq_vld !== '0 || mc_rq_vadr !== '0 || mc_rq_data !== '0) begin
      errors++; $display("FAIL reset_mc_req: vld=%h, required all mc outputs 0", mc_rq_vld); end
    checks++; if (mc_rq_cmd !== '0 || mc_rq_size !== '0 || mc_rs_stall !== '0) begin
      errors++; $display("FAIL reset_mc_ctl: cmd=%h size=%h, required 0", mc_rq_cmd, mc_rq_size); end
  endtask

  task automatic test_sim_end_zero();
    do_run(4, 0, 48'h2000, 8'hFF, 0, 0);
    checks++; if (obs_timeout !== 1'b0) begin errors++; $display("FAIL zero_timeout: no rtn_vld in %0d cycles", BUDGET); end
    checks++; if (obs_data.size() !== 0) begin errors++; $display("FAIL zero_writes: got %0d, required 0", obs_data.size()); end
    checks++; if (obs_k !== 5) begin errors++; $display("FAIL zero_latency: rtn_vld after %0d cycles, required 5", obs_k); end
    checks++; if (obs_tc !== 64'd5) begin errors++; $display("FAIL zero_cycles: got %0d, required 5", obs_tc); end
    checks++; if (obs_gvt !== 16'd0 || obs_te !== 64'd0) begin
      errors++; $display("FAIL zero_report: gvt=%0d events=%0d, required 0/0", obs_gvt, obs_te); end
    checks++; if (obs_extra !== 0 || obs_unfrozen !== 0 || obs_bad !== 0) begin
      errors++; $display("FAIL zero_done: extra=%0d unfrozen=%0d bad=%0d, required 0", obs_extra, obs_unfrozen, obs_bad); end
  endtask

  task automatic test_no_events();
    do_run(0, 100, 48'h3000, 8'hFF, 0, 0);
    checks++; if (obs_done !== 1'b1) begin errors++; $display("FAIL empty_done: rtn_vld not seen"); end
    checks++; if (obs_gvt !== 16'd100) begin errors++; $display("FAIL empty_gvt: got %0d, required 100", obs_gvt); end
    checks++; if (obs_te !== 64'd0 || obs_data.size() !== 0) begin
      errors++; $display("FAIL empty_events: events=%0d writes=%0d, required 0", obs_te, obs_data.size()); end
    checks++; if (obs_tc !== 64'd2) begin errors++; $display("FAIL empty_cycles: got %0d, required 2", obs_tc); end
  endtask

  task automatic test_single();
    do_run(1, 2, 48'h1000, 8'hFF, 0, 0);
    checks++; if (obs_data.size() !== 1) begin errors++; $display("FAIL single_count: got %0d writes, required 1", obs_data.size()); end
    else begin
      checks++; if (obs_vadr[0] !== 48'h1000 || obs_data[0] !== 64'd0) begin
        errors++; $display("FAIL single_write: vadr=%h data=%h, required 1000/0", obs_vadr[0], obs_data[0]); end
    end
    checks++; if (obs_te !== 64'd1 || obs_gvt !== 16'd2) begin
      errors++; $display("FAIL single_report: events=%0d gvt=%0d, required 1/2", obs_te, obs_gvt); end
    checks++; if (obs_tc !== 64'd3) begin errors++; $display("FAIL single_cycles: got %0d, required 3", obs_tc); end
  endtask

  task automatic test_random_stall();
    logic [47:0] base;
    int bad_addr, bad_order;
    base = {$urandom, 16'(($urandom) & 32'hFFF8)};
    do_run(8, 1000, base, 8'hFF, 50, 0);
    model_run(8, 1000, 8'hFF);
    bad_addr = 0; bad_order = 0;
    for (int i = 0; i < obs_vadr.size(); i++) begin
      if (obs_vadr[i] !== base + 48'(i) * 48'd8) bad_addr++;
      if (i > 0 && obs_data[i][15:0] < obs_data[i-1][15:0]) bad_order++;
    end
    checks++; if (obs_timeout !== 1'b0) begin errors++; $display("FAIL stall_timeout: no rtn_vld in %0d cycles", BUDGET); end
    checks++; if (64'(obs_data.size()) !== obs_te) begin
      errors++; $display("FAIL stall_count: writes=%0d events=%0d", obs_data.size(), obs_te); end
    checks++; if (obs_data.size() !== exp_t.size()) begin
      errors++; $display("FAIL stall_model_count: got %0d, required %0d", obs_data.size(), exp_t.size()); end
    checks++; if (bad_addr !== 0) begin errors++; $display("FAIL stall_vadr: %0d non-consecutive addresses, required 0", bad_addr); end
    checks++; if (bad_order !== 0) begin errors++; $display("FAIL stall_order: %0d decreasing times, required 0", bad_order); end
    checks++; if (seq_mismatches(base) !== 0) begin
      errors++; $display("FAIL stall_sequence: %0d writes differ from model, required 0", seq_mismatches(base)); end
    checks++; if (obs_tc !== 64'(obs_k)) begin errors++; $display("FAIL stall_cycles: got %0d, required %0d", obs_tc, obs_k); end
    checks++; if (obs_gvt !== 16'(exp_gvt)) begin errors++; $display("FAIL stall_gvt: got %0d, required %0d", obs_gvt, exp_gvt); end
    checks++; if (obs_bad !== 0 || obs_extra !== 0 || obs_unfrozen !== 0) begin
      errors++; $display("FAIL stall_protocol: bad=%0d extra=%0d unfrozen=%0d, required 0", obs_bad, obs_extra, obs_unfrozen); end
  endtask

  task automatic test_lp_mask();
    int big;
    do_run(12, 300, 48'h8_0000, 8'h03, 25, 0);
    model_run(12, 300, 8'h03);
    big = 0;
    foreach (obs_data[i]) if (obs_data[i][39:32] > 8'd3) big++;
    checks++; if (big !== 0) begin errors++; $display("FAIL mask_lp: %0d writes with lp>3, required 0", big); end
    checks++; if (seq_mismatches(48'h8_0000) !== 0 || obs_data.size() === 0) begin
      errors++; $display("FAIL mask_sequence: %0d mismatches of %0d writes, required 0", seq_mismatches(48'h8_0000), obs_data.size()); end
  endtask

  task automatic test_qdepth_clip();
    do_run(40, 60, 48'h4000, 8'hFF, 20, 0);
    model_run(40, 60, 8'hFF);
    checks++; if (seq_mismatches(48'h4000) !== 0) begin
      errors++; $display("FAIL clip_sequence: %0d mismatches, required 0", seq_mismatches(48'h4000)); end
    checks++; if (obs_tc !== 64'(obs_k) || obs_te !== 64'(exp_t.size())) begin
      errors++; $display("FAIL clip_totals: cycles=%0d/%0d events=%0d/%0d", obs_tc, obs_k, obs_te, exp_t.size()); end
  endtask

  task automatic test_mid_reset();
    logic [63:0] saved[$];
    int diff;
    do_run(8, 500, 48'h9000, 8'h0F, 0, 40);
    saved = obs_data;
    i_reset = 1'b1;
    #1;
    checks++; if (gvt !== 16'd0 || rtn_vld !== 1'b0 || total_cycles !== 64'd0 || total_events !== 64'd0 ||
                  mc_rq_vld !== '0 || mc_rq_data !== '0 || mc_rq_vadr !== '0) begin
      errors++; $display("FAIL midreset_outputs: cycles=%0d events=%0d vld=%h, required 0", total_cycles, total_events, mc_rq_vld); end
    do_run(8, 500, 48'h9000, 8'h0F, 30, 0);
    model_run(8, 500, 8'h0F);
    diff = 0;
    foreach (saved[i]) if (i >= obs_data.size() || saved[i] !== obs_data[i]) diff++;
    checks++; if (diff !== 0 || saved.size() === 0) begin
      errors++; $display("FAIL midreset_repeat: %0d of %0d writes differ, required 0", diff, saved.size()); end
    checks++; if (seq_mismatches(48'h9000) !== 0) begin
      errors++; $display("FAIL midreset_sequence: %0d mismatches, required 0", seq_mismatches(48'h9000)); end
  endtask

  task automatic test_random_configs();
    int num, send, mask, pct;
    logic [47:0] base;
    for (int r = 0; r < 3; r++) begin
      num  = $urandom_range(0, 20);
      send = $urandom_range(0, 400);
      mask = $urandom_range(0, 255);
      pct  = $urandom_range(0, 70);
      base = {$urandom, 16'(($urandom) & 32'hFFF8)};
      do_run(num, send, base, 8'(mask), pct, 0);
      model_run(num, send, mask);
      checks++; if (seq_mismatches(base) !== 0 || obs_done !== 1'b1) begin
        errors++; $display("FAIL rand_sequence: run %0d num=%0d end=%0d %0d mismatches", r, num, send, seq_mismatches(base)); end
      checks++; if (obs_gvt !== 16'(exp_gvt) || obs_te !== 64'(exp_t.size()) || obs_tc !== 64'(obs_k)) begin
        errors++; $display("FAIL rand_report: run %0d gvt=%0d/%0d events=%0d/%0d cycles=%0d/%0d",
                           r, obs_gvt, exp_gvt, obs_te, exp_t.size(), obs_tc, obs_k); end
    end
  endtask

  initial begin
    i_reset = 1'b1; sim_end = 16'd0; addr = 48'd0; num_init_events = 8'd0; lp_mask = 8'd0;
    mc_rq_stall = '0; mc_rs_vld = '0; mc_rs_cmd = '0; mc_rs_scmd = '0;
    mc_rs_rtnctl = '0; mc_rs_data = '0;
    test_reset();
    test_sim_end_zero();
    test_no_events();
    test_single();
    test_random_stall();
    test_lp_mask();
    test_qdepth_clip();
    test_mid_reset();
    test_random_configs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
